life_game_controller: RTL
=========================

// Module: life_game_controller
// PURPOSE
//  Sequencer for the Life cell-grid: owns run/pause/single-step, the generation rate,
//  the edit cursor and preset reload. Drives the grid's game_enable, write port and
//  active-low clear. Sits between the debounced board buttons and the grid.
// PARAMETERS
//  NR        20         grid rows
//  NC        20         grid columns
//  ADDR_LEN  6          width of row/col addresses
//  TICK_DIV  5_000_000  clocks per generation at speed=0; must be >= 128
// PORTS
//  clk          in   1         system clock
//  clr          in   1         async active-low reset
//  btn_run      in   1         1-cycle pulse: toggle run/pause
//  btn_step     in   1         1-cycle pulse: advance one generation (paused only)
//  btn_toggle   in   1         1-cycle pulse: invert cell under cursor (paused only)
//  btn_load     in   1         1-cycle pulse: reload preset
//  btn_up/down/left/right in 1 1-cycle pulses: move cursor (paused only)
//  speed        in   3         rate select; period = TICK_DIV >> speed clocks
//  preset_in    in   3         preset selection, latched on load
//  cur_state    in   1         current state of cell at (write_row, write_col)
//  game_enable  out  1         1-cycle pulse per generation
//  write_enable out  1         1-cycle grid write strobe
//  write_row    out  ADDR_LEN  cursor row (also the write address)
//  write_col    out  ADDR_LEN  cursor column
//  data_in      out  1         write data
//  grid_clr_n   out  1         active-low preset load to grid
//  preset_sel   out  3         latched preset
//  running      out  1         1 while in RUN
//  gen_count    out  16        generations since last load, wraps at 16 bits
// BEHAVIOUR
//  All outputs registered. Reset: state=LOAD, load_cnt=0, grid_clr_n=0, preset_sel=0,
//   cursor=(0,0), game_enable=0, write_enable=0, data_in=0, running=0, gen_count=0.
//  FSM states: LOAD, PAUSED, RUN, STEP, EDIT.
//  LOAD: grid_clr_n=0 for exactly 2 cycles, gen_count=0, tick counter=0, then PAUSED
//   with grid_clr_n=1. On entry from a button, preset_sel <= preset_in that cycle.
//  PAUSED: event priority btn_load > btn_run > btn_step > btn_toggle.
//   load->LOAD; run->RUN (counter restarts at 0); step->STEP; toggle->EDIT.
//   Cursor moves processed every PAUSED cycle regardless of other pulses; up/down
//   both high -> no row change; left/right likewise. Wrap: up at row 0 -> NR-1,
//   down at NR-1 -> 0, left at col 0 -> NC-1, right at NC-1 -> 0.
//  STEP: game_enable=1 for one cycle, gen_count+1, -> PAUSED. Ignores all buttons.
//  EDIT: write_enable=1, data_in=~cur_state (sampled on the EDIT-entry cycle) for one
//   cycle, -> PAUSED. Cursor frozen during EDIT.
//  RUN: running=1. Counter counts 0..P-1, P=TICK_DIV>>speed; speed re-sampled only
//   at wrap. At wrap: game_enable=1 for one cycle, gen_count+1. btn_load->LOAD,
//   btn_run->PAUSED (load wins if both). Step/toggle/moves ignored. A pause landing
//   on the wrap cycle still issues that generation.
//  Invariant: game_enable, write_enable, grid_clr_n=0 mutually exclusive.
//  Async reset mid-operation: all outputs jump to reset values immediately.
// STRUCTURE
//  Shared include life_ctrl_defs.vh: state encodings (LOAD/PAUSED/RUN/STEP/EDIT),
//   LOAD_CYCLES=2, GEN_W=16.
//  Sub-module gen_rate_divider (clk, clr, enable, restart, speed -> tick): the
//   period counter; controller instantiates one.
// TESTING (sim with TICK_DIV=16, NR=NC=20)
//  Release reset -> grid_clr_n low 2 cycles then high; state PAUSED, gen_count=0.
//  Paused, btn_step x3 -> exactly 3 single-cycle game_enable pulses, gen_count=3.
//  btn_run, speed=2 -> game_enable every 4 clocks; speed->0 mid-run takes effect at
//   next wrap (then every 16); btn_run -> no further pulses, running=0.
//  Cursor at (0,0): left -> col 19; up -> row 19; down x2 -> row 1; up+down same
//   cycle -> row unchanged.
//  Cursor (5,7), cur_state=0, btn_toggle -> write_enable 1 cycle, data_in=1,
//   write_row=5, write_col=7; with cur_state=1 -> data_in=0.
//  Running, btn_load+btn_run same cycle with preset_in=3 -> LOAD, preset_sel=3,
//   gen_count=0, no game_enable during clear; ends PAUSED.

Source files
------------

// File: rtl/life_game_controller_pkg.sv
// rtl/life_game_controller_pkg.sv - shared states, constants and cursor helper for the Life sequencer
package life_game_controller_pkg;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_PAUSED = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_EDIT   = 3'd4
  } ctrl_state_t;

  localparam int LOAD_CYCLES = 2;
  localparam int GEN_W       = 16;

  // Move a cursor coordinate by one with wraparound; inc and dec together cancel.
  function automatic int wrap_move(int pos, logic inc, logic dec, int n);
    int r;
    r = pos;
    if (inc && !dec) begin
      r = (pos == n - 1) ? 0 : pos + 1;
    end else if (dec && !inc) begin
      r = (pos == 0) ? n - 1 : pos - 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/life_game_controller_gen_rate_divider.sv
// rtl/life_game_controller_gen_rate_divider.sv - generation period counter with speed select
module gen_rate_divider #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       enable,
  input  logic       restart,
  input  logic [2:0] speed,
  output logic       tick
);

  localparam int CNT_W = $clog2(TICK_DIV + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] period_sel;
  logic             wrap;

  assign period_sel = CNT_W'(TICK_DIV >> speed);
  assign wrap       = (cnt == period - 1'b1);
  // restart is only raised outside RUN, so it never overlaps enable
  assign tick       = enable & wrap;

  // Count 0..period-1; speed is only re-sampled on restart and at wrap
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt    <= '0;
      period <= CNT_W'(TICK_DIV);
    end else if (restart) begin
      cnt    <= '0;
      period <= period_sel;
    end else if (enable) begin
      if (wrap) begin
        cnt    <= '0;
        period <= period_sel;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/life_game_controller.sv
// rtl/life_game_controller.sv - run/pause/step/edit/load sequencer for the Life cell grid
module life_game_controller
  import life_game_controller_pkg::*;
#(
  parameter int NR       = 20,
  parameter int NC       = 20,
  parameter int ADDR_LEN = 6,
  parameter int TICK_DIV = 5_000_000
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                btn_run,
  input  logic                btn_step,
  input  logic                btn_toggle,
  input  logic                btn_load,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic [2:0]          speed,
  input  logic [2:0]          preset_in,
  input  logic                cur_state,
  output logic                game_enable,
  output logic                write_enable,
  output logic [ADDR_LEN-1:0] write_row,
  output logic [ADDR_LEN-1:0] write_col,
  output logic                data_in,
  output logic                grid_clr_n,
  output logic [2:0]          preset_sel,
  output logic                running,
  output logic [GEN_W-1:0]    gen_count
);

  ctrl_state_t         state, state_d;
  logic [1:0]          load_cnt, load_cnt_d;
  logic [ADDR_LEN-1:0] row_d, col_d;
  logic                ge_d, we_d, din_d, clr_n_d;
  logic [2:0]          preset_d;
  logic [GEN_W-1:0]    gen_d;
  logic                tick, restart, div_en;

  assign div_en  = (state == ST_RUN);
  assign restart = (state == ST_LOAD) || (state == ST_PAUSED && state_d == ST_RUN);

  gen_rate_divider #(.TICK_DIV(TICK_DIV)) u_rate (
    .clk     (clk),
    .clr     (clr),
    .enable  (div_en),
    .restart (restart),
    .speed   (speed),
    .tick    (tick)
  );

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_d    = state;
    load_cnt_d = load_cnt;
    row_d      = write_row;
    col_d      = write_col;
    ge_d       = 1'b0;
    we_d       = 1'b0;
    din_d      = 1'b0;
    clr_n_d    = grid_clr_n;
    preset_d   = preset_sel;
    gen_d      = gen_count;
    case (state)
      ST_LOAD: begin
        gen_d = '0;
        if (load_cnt == 2'(LOAD_CYCLES - 1)) begin
          state_d = ST_PAUSED;
          clr_n_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt + 2'd1;
        end
      end
      ST_PAUSED: begin
        row_d = ADDR_LEN'(wrap_move(int'(write_row), btn_down, btn_up, NR));
        col_d = ADDR_LEN'(wrap_move(int'(write_col), btn_right, btn_left, NC));
        if (btn_load) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
          clr_n_d    = 1'b0;
          preset_d   = preset_in;
          gen_d      = '0;
        end else if (btn_run) begin
          state_d = ST_RUN;
        end else if (btn_step) begin
          state_d = ST_STEP;
          ge_d    = 1'b1;
          gen_d   = gen_count + 1'b1;
        end else if (btn_toggle) begin
          state_d = ST_EDIT;
          we_d    = 1'b1;
          din_d   = ~cur_state;
        end
      end
      ST_STEP, ST_EDIT: begin
        state_d = ST_PAUSED;
      end
      ST_RUN: begin
        if (btn_load) begin
          state_d    = ST_LOAD;
          load_cnt_d = '0;
          clr_n_d    = 1'b0;
          preset_d   = preset_in;
          gen_d      = '0;
        end else begin
          if (tick) begin
            ge_d  = 1'b1;
            gen_d = gen_count + 1'b1;
          end
          if (btn_run) begin
            state_d = ST_PAUSED;
          end
        end
      end
      default: begin
        state_d    = ST_LOAD;
        load_cnt_d = '0;
        clr_n_d    = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state        <= ST_LOAD;
      load_cnt     <= '0;
      write_row    <= '0;
      write_col    <= '0;
      game_enable  <= 1'b0;
      write_enable <= 1'b0;
      data_in      <= 1'b0;
      grid_clr_n   <= 1'b0;
      preset_sel   <= '0;
      running      <= 1'b0;
      gen_count    <= '0;
    end else begin
      state        <= state_d;
      load_cnt     <= load_cnt_d;
      write_row    <= row_d;
      write_col    <= col_d;
      game_enable  <= ge_d;
      write_enable <= we_d;
      data_in      <= din_d;
      grid_clr_n   <= clr_n_d;
      preset_sel   <= preset_d;
      running      <= (state_d == ST_RUN);
      gen_count    <= gen_d;
    end
  end

endmodule
